// File: rtl/seq_bcd_mult_pkg.sv
// Shared types and constants for the sequential BCD multiplier: FSM states,
// seven-segment glyphs and the digit-count legality helper.
package seq_bcd_mult_pkg;

    typedef enum logic [1:0] {IDLE, MUL, CONV, DONE} state_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Smallest DIGITS such that 10^DIGITS exceeds the largest possible product.
    function automatic int min_digits(input int width);
        longint unsigned max_op;
        longint unsigned max_p;
        longint unsigned lim;
        int d;
        max_op = (64'd1 << width) - 64'd1;
        max_p  = max_op * max_op;
        d      = 1;
        lim    = 64'd10;
        while (lim <= max_p) begin
            d   = d + 1;
            lim = lim * 64'd10;
        end
        return d;
    endfunction

endpackage

// File: rtl/seq_bcd_multiplier_seg7.sv
// Single-digit seven-segment encoder (bit0=a .. bit6=g, active-high);
// a blanked digit or a non-decimal nibble shows no segments.
module seg7_encode
    import seq_bcd_mult_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // NOTE: seg gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seq_bcd_multiplier.sv
// Sequential shift-add multiplier followed by double-dabble BCD conversion and
// seven-segment encoding. Optional build macro: LEADING_ZERO_BLANK_EN.
module seq_bcd_multiplier
    import seq_bcd_mult_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    output logic                  busy,
    output logic                  done,
    output logic [2*WIDTH-1:0]    product,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int PW    = 2 * WIDTH;
    localparam int BW    = 4 * DIGITS;
    localparam int DW    = BW + PW;
    localparam int CNT_W = $clog2(PW);

    if (WIDTH < 2 || WIDTH > 8) begin : g_bad_width
        $error("seq_bcd_multiplier: WIDTH must be within 2..8");
    end
    if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
        $error("seq_bcd_multiplier: DIGITS too small for WIDTH");
    end

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand, mplier;
    logic [PW-1:0]      acc;
    logic [DW-1:0]      dd, dd_adj, dd_shift;
    logic [PW-1:0]      product_q;
    logic [BW-1:0]      bcd_q;
    logic [DIGITS-1:0]  blank;

    // One double-dabble step: correct every BCD nibble >= 5, then shift left.
    always_comb begin
        dd_adj = dd;
        for (int i = 0; i < DIGITS; i++) begin
            if (dd[PW+4*i +: 4] >= 4'd5)
                dd_adj[PW+4*i +: 4] = dd[PW+4*i +: 4] + 4'd3;
        end
        dd_shift = dd_adj << 1;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start)                       state_nx = MUL;
            MUL:  if (cnt == CNT_W'(WIDTH))        state_nx = CONV;
            CONV: if (cnt == CNT_W'(PW - 1))       state_nx = DONE;
            DONE:                                  state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            dd        <= '0;
            product_q <= '0;
            bcd_q     <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: if (start) begin
                    mcand  <= a;
                    mplier <= b;
                    acc    <= '0;
                    cnt    <= '0;
                end
                // WIDTH add/shift steps, then one extra cycle to load the converter.
                MUL: if (cnt == CNT_W'(WIDTH)) begin
                    dd  <= {{BW{1'b0}}, acc};
                    cnt <= '0;
                end else begin
                    if (mplier[0])
                        acc <= acc + (PW'(mcand) << cnt);
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                CONV: begin
                    dd  <= dd_shift;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(PW - 1)) begin
                        product_q <= acc;
                        bcd_q     <= dd_shift[DW-1 -: BW];
                    end
                end
                DONE: ;
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic lead_zero;

    // Blank zero digits from the top down until the first non-zero; digit 0 always shows.
    always_comb begin
        blank     = '0;
        lead_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead_zero = lead_zero && (bcd_q[4*i +: 4] == 4'd0);
            blank[i]  = lead_zero;
        end
    end
`else
    assign blank = '0;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        seg7_encode u_seg7 (
            .digit (bcd_q[4*g +: 4]),
            .blank (blank[g]),
            .seg   (seg[7*g +: 7])
        );
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign product = product_q;
    assign bcd     = bcd_q;

endmodule

// File: tb/tb_seq_bcd_multiplier.sv
// Self-checking bench: a cycle-level latency model compared every cycle on the
// 4-bit instance, directed literal cases, and a WIDTH=8 instance for the wide path.
module tb_seq_bcd_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  a = '0, b = '0;
    logic        busy, done;
    logic [7:0]  product;
    logic [11:0] bcd;
    logic [20:0] seg;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] product8;
    logic [19:0] bcd8;
    logic [34:0] seg8;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_bcd_multiplier #(.WIDTH(4), .DIGITS(3)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product), .bcd(bcd), .seg(seg)
    );

    seq_bcd_multiplier #(.WIDTH(8), .DIGITS(5)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(product8), .bcd(bcd8), .seg(seg8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int unsigned p);
        logic [19:0] r;
        int unsigned v;
        r = '0;
        v = p;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;  default: return 7'h00;
        endcase
    endfunction

    function automatic logic [34:0] to_seg(input logic [19:0] bcd_v, input int ndig);
        logic [34:0] r;
        logic [3:0]  d;
        bit          lead;
        r    = '0;
        lead = 1'b1;
        for (int i = ndig - 1; i >= 0; i--) begin
            d    = bcd_v[4*i +: 4];
            lead = lead && (d == 4'd0);
`ifdef LEADING_ZERO_BLANK_EN
            r[7*i +: 7] = (lead && i != 0) ? 7'h00 : glyph(d);
`else
            r[7*i +: 7] = glyph(d);
`endif
        end
        return r;
    endfunction

    // Latency model of the 4-bit instance: an accepted start makes the block busy
    // for 3*WIDTH+2 cycles, the last of which is the done cycle carrying the result.
    int          m_rem  = 0;
    int unsigned m_a    = 0, m_b = 0;
    int unsigned m_prod = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_rem  = 0;
            m_prod = 0;
        end else if (m_rem == 0) begin
            if (start) begin
                m_rem = 3 * 4 + 2;
                m_a   = a;
                m_b   = b;
            end
        end else begin
            m_rem--;
            if (m_rem == 1)
                m_prod = m_a * m_b;
        end
    end

    always @(negedge clk) begin
        check("busy",    64'(busy),    64'(m_rem != 0));
        check("done",    64'(done),    64'(m_rem == 1));
        check("product", 64'(product), 64'(m_prod));
        check("bcd",     64'(bcd),     64'(to_bcd(m_prod) & 20'h00FFF));
        check("seg",     64'(seg),     64'(to_seg(to_bcd(m_prod), 3) & 35'h1FFFFF));
    end

    task automatic run_op(input logic [3:0] aa, input logic [3:0] bb, output int lat);
        @(negedge clk);
        a = aa; b = bb; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 0; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        check("op_done_seen", 64'(lat >= 0), 64'd1);
    endtask

    task automatic run_op8(input logic [7:0] aa, input logic [7:0] bb, output int lat);
        @(negedge clk);
        a8 = aa; b8 = bb; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        lat = -1;
        for (int i = 0; i <= 60; i++) begin
            @(negedge clk);
            if (done8) begin
                lat = i;
                break;
            end
        end
        check("op8_done_seen", 64'(lat >= 0), 64'd1);
    endtask

    initial begin
        int lat;
        int ndone;
        logic [34:0] seg_exp;

        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state, literal glyphs.
`ifdef LEADING_ZERO_BLANK_EN
        check("rst_seg", 64'(seg), 64'({7'h00, 7'h00, 7'h3F}));
`else
        check("rst_seg", 64'(seg), 64'({7'h3F, 7'h3F, 7'h3F}));
`endif
        check("rst_busy8",    64'(busy8),    64'd0);
        check("rst_product8", 64'(product8), 64'd0);

        run_op(4'd3, 4'd5, lat);
        check("lat_3x5",     64'(lat),     64'd13);
        check("prod_3x5",    64'(product), 64'd15);
        check("bcd_3x5",     64'(bcd),     64'h015);
`ifdef LEADING_ZERO_BLANK_EN
        check("seg_3x5", 64'(seg), 64'({7'h00, 7'h06, 7'h6D}));
`else
        check("seg_3x5", 64'(seg), 64'({7'h3F, 7'h06, 7'h6D}));
`endif

        run_op(4'd15, 4'd15, lat);
        check("prod_15x15", 64'(product), 64'd225);
        check("bcd_15x15",  64'(bcd),     64'h225);
        check("seg_15x15",  64'(seg),     64'({7'h5B, 7'h5B, 7'h6D}));

        run_op(4'd0, 4'd9, lat);
        check("prod_0x9", 64'(product), 64'd0);
        check("bcd_0x9",  64'(bcd),     64'h000);
`ifdef LEADING_ZERO_BLANK_EN
        check("seg_0x9", 64'(seg), 64'({7'h00, 7'h00, 7'h3F}));
`else
        check("seg_0x9", 64'(seg), 64'({7'h3F, 7'h3F, 7'h3F}));
`endif

        // Start while busy is ignored.
        @(negedge clk);
        a = 4'd3; b = 4'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 3) begin
                a = 4'd15; b = 4'd15; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) ndone++;
        end
        check("busy_start_ndone", 64'(ndone),   64'd1);
        check("busy_start_prod",  64'(product), 64'd15);
        run_op(4'd15, 4'd15, lat);
        check("after_ignored_prod", 64'(product), 64'd225);

        // Reset during conversion.
        @(negedge clk);
        a = 4'd15; b = 4'd15; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 8; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy",    64'(busy),    64'd0);
        check("midrst_product", 64'(product), 64'd0);
        check("midrst_bcd",     64'(bcd),     64'd0);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst_no_done", 64'(ndone), 64'd0);
        run_op(4'd2, 4'd3, lat);
        check("after_rst_prod", 64'(product), 64'd6);

        // start held high: back-to-back operations, period 3*WIDTH+3.
        @(negedge clk);
        a = 4'd7; b = 4'd9; start = 1'b1;
        ndone = 0;
        for (int i = 0; i <= 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        start = 1'b0;
        check("held_start_ndone", 64'(ndone), 64'd2);
        repeat (20) @(negedge clk);

        // Random traffic: operands change every cycle, stray starts, rare resets.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            a     = 4'($urandom_range(0, 15));
            b     = 4'($urandom_range(0, 15));
            start = ($urandom_range(0, 2) == 0);
            rst   = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        repeat (20) @(negedge clk);

        // Wide instance.
        run_op8(8'd255, 8'd255, lat);
        check("lat8_255x255",  64'(lat),      64'd25);
        check("prod8_255x255", 64'(product8), 64'd65025);
        check("bcd8_255x255",  64'(bcd8),     64'h65025);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_op8(ra, rb, lat);
            seg_exp = to_seg(to_bcd(ra * rb), 5);
            check("prod8_rand", 64'(product8), 64'(int'(ra) * int'(rb)));
            check("bcd8_rand",  64'(bcd8),     64'(to_bcd(int'(ra) * int'(rb))));
            check("seg8_rand",  64'(seg8),     64'(seg_exp));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
